// File: rtl/riscv_mmio_timer_if.sv
// Data-memory port between the RISC-V core (master) and an MMIO responder (slave).
// Signal names follow the responder's view: _i driven by the core, _o returned to it.
interface riscv_mmio_timer_if;
  logic [31:0] daddr_i;
  logic [31:0] dwdata_i;
  logic [1:0]  dsize_i;
  logic        drd_i;
  logic        dwr_i;
  logic [31:0] drdata_o;
  logic        dhit_o;

  modport master (
    output daddr_i, dwdata_i, dsize_i, drd_i, dwr_i,
    input  drdata_o, dhit_o
  );

  modport slave (
    input  daddr_i, dwdata_i, dsize_i, drd_i, dwr_i,
    output drdata_o, dhit_o
  );
endinterface

// File: rtl/riscv_mmio_timer.sv
// MMIO timer: 16-byte window (CTRL/COUNT/CMP/STATUS), prescaled 32-bit counter, match/overflow irq.
// Optional one-shot mode (CTRL bit3) is built only when RISCV_TIMER_ONESHOT_EN is defined.
module riscv_mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  riscv_mmio_timer_if.slave  dbus,
  output logic               irq_o
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic                  en_q, en_d;
  logic                  auto_q, auto_d;
  logic                  irqen_q, irqen_d;
`ifdef RISCV_TIMER_ONESHOT_EN
  logic                  oneshot_q, oneshot_d;
`endif
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           cmp_q, cmp_d;
  logic                  match_q, match_d;
  logic                  ovf_q, ovf_d;
  logic [31:0]           drdata_q, drdata_d;
  logic                  dhit_q, dhit_d;

  logic        hit;
  logic [1:0]  sel;
  logic [3:0]  be;
  logic [31:0] wmask;
  logic        wr_any, wr_ctrl, wr_count, wr_cmp, wr_status;
  logic        rd_hit;
  logic [31:0] ctrl_rd, rd_word;
  logic        tick, cnt_eq_cmp, cnt_max, set_match, set_ovf;
  logic [31:0] count_hw;

  assign hit = (dbus.daddr_i[31:4] == BASE_ADDR[31:4]);
  assign sel = dbus.daddr_i[3:2];

  // Misaligned half/word accesses and the reserved size produce no lane enables.
  always_comb begin
    be = 4'b0000;
    case (dbus.dsize_i)
      2'd0:    be[dbus.daddr_i[1:0]] = 1'b1;
      2'd1:    if (!dbus.daddr_i[0]) be = dbus.daddr_i[1] ? 4'b1100 : 4'b0011;
      2'd2:    if (dbus.daddr_i[1:0] == 2'b00) be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  assign wr_any    = dbus.dwr_i & hit & (|be);
  assign wr_ctrl   = wr_any & (sel == REG_CTRL);
  assign wr_count  = wr_any & (sel == REG_COUNT);
  assign wr_cmp    = wr_any & (sel == REG_CMP);
  assign wr_status = wr_any & (sel == REG_STATUS);
  assign rd_hit    = dbus.drd_i & hit;

  assign tick       = en_q & (presc_q == prescale_q);
  assign cnt_eq_cmp = (count_q == cmp_q);
  assign cnt_max    = &count_q;
  assign set_match  = tick & cnt_eq_cmp;
  assign set_ovf    = tick & ~cnt_eq_cmp & cnt_max;

  always_comb begin
    ctrl_rd    = '0;
    ctrl_rd[0] = en_q;
    ctrl_rd[1] = auto_q;
    ctrl_rd[2] = irqen_q;
`ifdef RISCV_TIMER_ONESHOT_EN
    ctrl_rd[3] = oneshot_q;
`endif
    ctrl_rd[16 +: PRESCALE_W] = prescale_q;
  end

  always_comb begin
    rd_word = '0;
    case (sel)
      REG_CTRL:   rd_word = ctrl_rd;
      REG_COUNT:  rd_word = count_q;
      REG_CMP:    rd_word = cmp_q;
      REG_STATUS: rd_word = {30'd0, ovf_q, match_q};
      default:    rd_word = '0;
    endcase
  end

  always_comb begin
    count_hw = count_q;
    if (tick) begin
      if (cnt_eq_cmp)   count_hw = auto_q ? 32'd0 : count_q + 32'd1;
      else if (cnt_max) count_hw = 32'd0;
      else              count_hw = count_q + 32'd1;
    end
  end

  // Bus writes override the hardware update lane by lane; flag sets use the pre-write COUNT.
  always_comb begin
    count_d = wr_count ? ((count_hw & ~wmask) | (dbus.dwdata_i & wmask)) : count_hw;
    cmp_d   = wr_cmp ? ((cmp_q & ~wmask) | (dbus.dwdata_i & wmask)) : cmp_q;

    match_d = set_match | (match_q & ~(wr_status & be[0] & dbus.dwdata_i[0]));
    ovf_d   = set_ovf   | (ovf_q   & ~(wr_status & be[0] & dbus.dwdata_i[1]));

    presc_d = presc_q;
    if (wr_ctrl)   presc_d = '0;
    else if (en_q) presc_d = tick ? '0 : presc_q + 1'b1;

    en_d    = en_q;
    auto_d  = auto_q;
    irqen_d = irqen_q;
`ifdef RISCV_TIMER_ONESHOT_EN
    oneshot_d = oneshot_q;
    if (set_match & oneshot_q) en_d = 1'b0;
`endif
    if (wr_ctrl & be[0]) begin
      en_d    = dbus.dwdata_i[0];
      auto_d  = dbus.dwdata_i[1];
      irqen_d = dbus.dwdata_i[2];
`ifdef RISCV_TIMER_ONESHOT_EN
      oneshot_d = dbus.dwdata_i[3];
`endif
    end

    prescale_d = prescale_q;
    for (int i = 0; i < PRESCALE_W; i++) begin
      if (wr_ctrl & wmask[16+i]) prescale_d[i] = dbus.dwdata_i[16+i];
    end

    drdata_d = rd_hit ? rd_word : 32'd0;
    dhit_d   = rd_hit;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      irqen_q    <= 1'b0;
`ifdef RISCV_TIMER_ONESHOT_EN
      oneshot_q  <= 1'b0;
`endif
      prescale_q <= '0;
      presc_q    <= '0;
      count_q    <= '0;
      cmp_q      <= '0;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
      drdata_q   <= '0;
      dhit_q     <= 1'b0;
    end else begin
      en_q       <= en_d;
      auto_q     <= auto_d;
      irqen_q    <= irqen_d;
`ifdef RISCV_TIMER_ONESHOT_EN
      oneshot_q  <= oneshot_d;
`endif
      prescale_q <= prescale_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      drdata_q   <= drdata_d;
      dhit_q     <= dhit_d;
    end
  end

  assign dbus.drdata_o = drdata_q;
  assign dbus.dhit_o   = dhit_q;
  assign irq_o         = irqen_q & (match_q | ovf_q);

endmodule

// File: tb/tb_riscv_mmio_timer.sv
// Directed and randomized checks of riscv_mmio_timer against a cycle-count reference model.
module tb_riscv_mmio_timer;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic clk = 1'b0;
  logic reset;
  logic irq;
  int   total = 0;
  int   bad   = 0;

  riscv_mmio_timer_if bus_if ();

  riscv_mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .dbus    (bus_if),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    bus_if.daddr_i  = a;
    bus_if.dwdata_i = d;
    bus_if.dsize_i  = sz;
    bus_if.dwr_i    = 1'b1;
    bus_if.drd_i    = 1'b0;
    cyc();
    bus_if.dwr_i    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus_if.daddr_i = a;
    bus_if.dsize_i = 2'd2;
    bus_if.drd_i   = 1'b1;
    bus_if.dwr_i   = 1'b0;
    cyc();
    bus_if.drd_i   = 1'b0;
    d = bus_if.drdata_o;
    h = bus_if.dhit_o;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        h;
    rd(a, d, h);
    chk({tag, "_hit"}, {31'd0, h}, 32'd1);
    chk(tag, d, exp);
  endtask

  // Lanes written by an access of size sz at byte offset off within a word.
  function automatic logic [3:0] lanes_of(input int sz, input int off);
    case (sz)
      0:       return 4'(1 << off);
      1:       return (off % 2 == 0) ? 4'(3 << off) : 4'd0;
      2:       return (off == 0) ? 4'hF : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, wd, m_exp;
    logic        h;
    logic [31:0] mreg [4];
    logic [3:0]  ln;
    int          r, sz, off, p, c, n, ticks;

    bus_if.daddr_i  = '0;
    bus_if.dwdata_i = '0;
    bus_if.dsize_i  = '0;
    bus_if.drd_i    = 1'b0;
    bus_if.dwr_i    = 1'b0;
    reset = 1'b1;
    idle(3);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_dhit", {31'd0, bus_if.dhit_o}, 32'd0);
    chk("rst_drdata", bus_if.drdata_o, 32'd0);
    reset = 1'b0;
    rd_chk("rst_ctrl", BASE + 32'h0, 32'd0);
    rd_chk("rst_count", BASE + 32'h4, 32'd0);
    rd_chk("rst_cmp", BASE + 32'h8, 32'd0);
    rd_chk("rst_status", BASE + 32'hC, 32'd0);
    rd(BASE + 32'h10, d, h);
    chk("miss_hit", {31'd0, h}, 32'd0);
    chk("miss_data", d, 32'd0);

    // Match with auto-reload and irq, prescale 0
    wr(BASE + 32'h8, 32'd5, 2'd2);
    wr(BASE + 32'h0, 32'h7, 2'd2);
    for (int k = 0; k < 7; k++) begin
      rd(BASE + 32'h4, d, h);
      chk($sformatf("run_count%0d", k), d, (k == 6) ? 32'd0 : 32'(k));
      if (k == 4) chk("irq_before_match", {31'd0, irq}, 32'd0);
      if (k == 5) chk("irq_after_match", {31'd0, irq}, 32'd1);
    end
    wr(BASE + 32'h0, 32'h4, 2'd2);
    chk("irq_held", {31'd0, irq}, 32'd1);
    rd_chk("status_match", BASE + 32'hC, 32'h1);
    wr(BASE + 32'hC, 32'h1, 2'd2);
    chk("irq_cleared", {31'd0, irq}, 32'd0);

    // Lane handling
    wr(BASE + 32'h0, 32'h0, 2'd2);
    wr(BASE + 32'h8, 32'h0, 2'd2);
    wr(BASE + 32'h9, 32'h0000_AB00, 2'd0);
    wr(BASE + 32'hA, 32'h1234_0000, 2'd1);
    rd_chk("cmp_lanes", BASE + 32'h8, 32'h1234_AB00);
    wr(BASE + 32'h9, 32'hFFFF_FFFF, 2'd1);
    wr(BASE + 32'h9, 32'hFFFF_FFFF, 2'd2);
    wr(BASE + 32'h8, 32'hFFFF_FFFF, 2'd3);
    rd_chk("cmp_misaligned_ignored", BASE + 32'h8, 32'h1234_AB00);
    bus_if.daddr_i  = BASE + 32'h8;
    bus_if.dwdata_i = 32'h55AA_55AA;
    bus_if.dsize_i  = 2'd2;
    bus_if.drd_i    = 1'b1;
    bus_if.dwr_i    = 1'b1;
    cyc();
    bus_if.drd_i = 1'b0;
    bus_if.dwr_i = 1'b0;
    chk("rdwr_old_value", bus_if.drdata_o, 32'h1234_AB00);
    rd_chk("rdwr_new_value", BASE + 32'h8, 32'h55AA_55AA);

    // Overflow with prescale 3, irq disabled
    wr(BASE + 32'hC, 32'h3, 2'd2);
    wr(BASE + 32'h4, 32'hFFFF_FFFE, 2'd2);
    wr(BASE + 32'h8, 32'h0, 2'd2);
    wr(BASE + 32'h0, 32'h0003_0001, 2'd2);
    idle(3);
    rd_chk("ovf_c4", BASE + 32'h4, 32'hFFFF_FFFE);
    rd_chk("ovf_c5", BASE + 32'h4, 32'hFFFF_FFFF);
    idle(2);
    rd_chk("ovf_c8", BASE + 32'h4, 32'hFFFF_FFFF);
    rd_chk("ovf_c9", BASE + 32'h4, 32'h0);
    rd_chk("ovf_status", BASE + 32'hC, 32'h2);
    chk("ovf_irq_masked", {31'd0, irq}, 32'd0);
    wr(BASE + 32'h0, 32'h0, 2'd2);

    // COUNT write colliding with a matching tick
    wr(BASE + 32'hC, 32'h3, 2'd2);
    wr(BASE + 32'h4, 32'h3, 2'd2);
    wr(BASE + 32'h8, 32'h3, 2'd2);
    wr(BASE + 32'h0, 32'h1, 2'd2);
    wr(BASE + 32'h4, 32'h100, 2'd2);
    rd_chk("collide_count", BASE + 32'h4, 32'h100);
    rd_chk("collide_match", BASE + 32'hC, 32'h1);
    wr(BASE + 32'h0, 32'h0, 2'd2);

    // W1C colliding with a new match, prescale 1
    wr(BASE + 32'hC, 32'h3, 2'd2);
    wr(BASE + 32'h4, 32'h0, 2'd2);
    wr(BASE + 32'h8, 32'h0, 2'd2);
    wr(BASE + 32'h0, 32'h0001_0003, 2'd2);
    idle(3);
    wr(BASE + 32'hC, 32'h1, 2'd2);
    wr(BASE + 32'h0, 32'h0, 2'd2);
    rd_chk("w1c_set_wins", BASE + 32'hC, 32'h1);
    wr(BASE + 32'hC, 32'h1, 2'd2);
    rd_chk("w1c_clears", BASE + 32'hC, 32'h0);

    // One-shot
    wr(BASE + 32'h4, 32'h0, 2'd2);
    wr(BASE + 32'h8, 32'h2, 2'd2);
`ifdef RISCV_TIMER_ONESHOT_EN
    wr(BASE + 32'h0, 32'h9, 2'd2);
    idle(5);
    rd_chk("oneshot_ctrl", BASE + 32'h0, 32'h8);
    rd_chk("oneshot_count", BASE + 32'h4, 32'h3);
    wr(BASE + 32'h4, 32'h0, 2'd2);
    wr(BASE + 32'h0, 32'hB, 2'd2);
    idle(5);
    rd_chk("oneshot_auto_ctrl", BASE + 32'h0, 32'hA);
    rd_chk("oneshot_auto_count", BASE + 32'h4, 32'h0);
`else
    wr(BASE + 32'h0, 32'hB, 2'd2);
    idle(5);
    rd_chk("no_oneshot_ctrl", BASE + 32'h0, 32'h3);
`endif
    wr(BASE + 32'h0, 32'h0, 2'd2);
    wr(BASE + 32'hC, 32'h3, 2'd2);

    // Random byte/half/word writes to COUNT and CMP with timer stopped
    wr(BASE + 32'h4, 32'h0, 2'd2);
    wr(BASE + 32'h8, 32'h0, 2'd2);
    mreg[0] = '0; mreg[1] = '0; mreg[2] = '0; mreg[3] = '0;
    for (int i = 0; i < 40; i++) begin
      r   = int'($urandom_range(1, 2));
      sz  = int'($urandom_range(0, 3));
      off = int'($urandom_range(0, 3));
      wd  = $urandom;
      wr(BASE + 32'(r * 4 + off), wd, 2'(sz));
      ln = lanes_of(sz, off);
      m_exp = mreg[r];
      for (int b = 0; b < 4; b++) if (ln[b]) m_exp[8*b +: 8] = wd[8*b +: 8];
      mreg[r] = m_exp;
      rd_chk($sformatf("rand_reg%0d", i), BASE + 32'(r * 4), mreg[r]);
    end

    // Random prescale/compare runs: ticks = enabled cycles / (PRESCALE+1)
    for (int t = 0; t < 6; t++) begin
      p = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 6));
      n = int'($urandom_range(4, 40));
      wr(BASE + 32'h0, 32'h0, 2'd2);
      wr(BASE + 32'hC, 32'h3, 2'd2);
      wr(BASE + 32'h4, 32'h0, 2'd2);
      wr(BASE + 32'h8, 32'(c), 2'd2);
      wr(BASE + 32'h0, 32'h3 | (32'(p) << 16), 2'd2);
      idle(n - 1);
      wr(BASE + 32'h0, 32'h0, 2'd2);
      ticks = n / (p + 1);
      rd_chk($sformatf("rand_run%0d_count", t), BASE + 32'h4, 32'(ticks % (c + 1)));
      rd_chk($sformatf("rand_run%0d_status", t), BASE + 32'hC, (ticks > c) ? 32'h1 : 32'h0);
    end

    // Reset while running and with a read in flight
    wr(BASE + 32'h4, 32'h77, 2'd2);
    wr(BASE + 32'h0, 32'h5, 2'd2);
    bus_if.daddr_i = BASE + 32'h4;
    bus_if.drd_i   = 1'b1;
    reset = 1'b1;
    cyc();
    bus_if.drd_i = 1'b0;
    chk("midrst_dhit", {31'd0, bus_if.dhit_o}, 32'd0);
    chk("midrst_drdata", bus_if.drdata_o, 32'd0);
    cyc();
    reset = 1'b0;
    rd_chk("midrst_count", BASE + 32'h4, 32'h0);
    rd_chk("midrst_ctrl", BASE + 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
